updown_ctrl: RTL and testbench

Wishbone-controlled sequencer for the user-area up/down counter. Owns the counter state and is the only writer to it. Arbitrates between three sources of update (logic-analyzer load, Wishbone register write, prescaled count step), detects the terminal value, and raises a maskable interrupt. Sits directly below the user project wrapper, on the management Wishbone slave port, the LA bus and the GPIO pads.

---
 rtl/updown_ctrl_if.sv | 36 +++
 rtl/updown_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_updown_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/updown_ctrl_if.sv
// ---------------------------------------------------------------------------
// updown_ctrl_if
//
// Wishbone classic slave bus used by updown_ctrl. The names match the
// management-SoC wrapper signals so the wrapper can connect them directly.
//
//   wbs_stb_i / wbs_cyc_i / wbs_we_i  strobe, cycle, write enable
//   wbs_sel_i [3:0]                   byte enables for writes
//   wbs_adr_i [31:0]                  byte address
//   wbs_dat_i [31:0]                  write data
//   wbs_ack_o                         single-cycle acknowledge
//   wbs_dat_o [31:0]                  read data, zero while wbs_ack_o=0
//
// master: drives the request side (management core or testbench).
// slave : drives ack and read data (updown_ctrl).
// ---------------------------------------------------------------------------
interface updown_ctrl_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/updown_ctrl.sv
// ---------------------------------------------------------------------------
// updown_ctrl
//
// Wishbone-controlled up/down counter sequencer. This block is the only
// writer of the counter. Three update sources are arbitrated (LA load over
// Wishbone COUNT write over prescaled step), the terminal value is detected
// and a sticky hit flag drives a maskable, registered interrupt.
//
// Ports:
//   wb_clk_i   sole clock, rising edge
//   wb_rst_ni  synchronous, active-low reset
//   wb         Wishbone classic slave (updown_ctrl_if.slave)
//   la_load_i  LA load request (level), honoured only while la_oenb_i=0
//   la_oenb_i  LA enable, active-low
//   la_data_i  LA load value
//   count_o    current counter value
//   io_oeb_o   pad output-enable bar, every bit = ~CTRL.oe
//   irq_o      registered STATUS.hit & CTRL.irq_en
//
// Register map (offset from BASE):
//   0x00 CTRL     [0] en [1] dir(1=up) [2] irq_en [3] wrap_en [4] oe
//   0x04 COUNT    read counter / write load
//   0x08 LIMIT    up-count terminal value
//   0x0C STATUS   [0] hit, sticky, write 1 to clear
//   0x10 PRESCALE [15:0], one step every PRESCALE+1 cycles
// ---------------------------------------------------------------------------
module updown_ctrl #(
    parameter int          BITS = 32,
    parameter logic [31:0] BASE = 32'h3000_0000
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    updown_ctrl_if.slave    wb,
    input  logic            la_load_i,
    input  logic            la_oenb_i,
    input  logic [BITS-1:0] la_data_i,
    output logic [BITS-1:0] count_o,
    output logic [BITS-1:0] io_oeb_o,
    output logic            irq_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

    // Word indices (byte offset >> 2) inside the 256-byte window.
    localparam logic [5:0] W_CTRL     = 6'h00;
    localparam logic [5:0] W_COUNT    = 6'h01;
    localparam logic [5:0] W_LIMIT    = 6'h02;
    localparam logic [5:0] W_STATUS   = 6'h03;
    localparam logic [5:0] W_PRESCALE = 6'h04;

    localparam logic [BITS-1:0] ONE = BITS'(1);

    // State
    logic [0:0]      state_reg, state_next;
    logic [31:0]     dat_o_reg, dat_o_next;
    logic [4:0]      ctrl_reg, ctrl_next;
    logic [BITS-1:0] count_reg, count_next;
    logic [BITS-1:0] limit_reg, limit_next;
    logic            hit_reg, hit_next;
    logic [15:0]     prescale_reg, prescale_next;
    logic [15:0]     pre_cnt_reg, pre_cnt_next;
    logic            irq_reg;

    // Decode
    logic        in_window;
    logic        req;
    logic        wr;
    logic [5:0]  word;
    logic [31:0] byte_mask;
    logic [31:0] rd_data;
    logic [31:0] wr_merged;
    logic [31:0] count_ext;
    logic [31:0] limit_ext;

    // Counter control
    logic        en, dir, wrap_en;
    logic        la_load;
    logic        wb_count_wr;
    logic        tick;
    logic        at_term;
    logic        step_ok;
    logic        auto_clear;

    logic        unused_adr;
    assign unused_adr = &{1'b0, wb.wbs_adr_i[1:0]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte_mask
            assign byte_mask[gi*8 +: 8] = {8{wb.wbs_sel_i[gi]}};
        end
    endgenerate

    always_comb begin
        count_ext             = '0;
        count_ext[BITS-1:0]   = count_reg;
        limit_ext             = '0;
        limit_ext[BITS-1:0]   = limit_reg;
    end

    assign in_window = (wb.wbs_adr_i[31:8] == BASE[31:8]);
    assign req       = wb.wbs_stb_i & wb.wbs_cyc_i & in_window & (state_reg == ST_IDLE);
    assign wr        = req & wb.wbs_we_i;
    assign word      = wb.wbs_adr_i[7:2];

    // Current register image at the addressed word; also the base for byte merges.
    always_comb begin
        rd_data = '0;
        case (word)
            W_CTRL:     rd_data = {27'd0, ctrl_reg};
            W_COUNT:    rd_data = count_ext;
            W_LIMIT:    rd_data = limit_ext;
            W_STATUS:   rd_data = {31'd0, hit_reg};
            W_PRESCALE: rd_data = {16'd0, prescale_reg};
            default:    rd_data = '0;
        endcase
    end

    assign wr_merged = (rd_data & ~byte_mask) | (wb.wbs_dat_i & byte_mask);

    assign en      = ctrl_reg[0];
    assign dir     = ctrl_reg[1];
    assign wrap_en = ctrl_reg[3];

    assign la_load     = la_load_i & ~la_oenb_i;
    assign wb_count_wr = wr & (word == W_COUNT);
    assign tick        = en & (pre_cnt_reg == prescale_reg);
    assign at_term     = dir ? (count_reg == limit_reg) : (count_reg == '0);
    // A step that loses to either load is dropped entirely, including its hit.
    assign step_ok     = tick & ~la_load & ~wb_count_wr;
    assign auto_clear  = step_ok & at_term & ~wrap_en;

    always_comb begin
        state_next    = state_reg;
        dat_o_next    = '0;
        ctrl_next     = ctrl_reg;
        count_next    = count_reg;
        limit_next    = limit_reg;
        hit_next      = hit_reg;
        prescale_next = prescale_reg;
        pre_cnt_next  = pre_cnt_reg;

        // Bus FSM: ACK always lasts one cycle, so back-to-back strobes are
        // served every other cycle.
        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    state_next = ST_ACK;
                    dat_o_next = wb.wbs_we_i ? 32'd0 : rd_data;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (wr && word == W_CTRL)     ctrl_next     = wr_merged[4:0];
        if (wr && word == W_LIMIT)    limit_next    = wr_merged[BITS-1:0];
        if (wr && word == W_PRESCALE) prescale_next = wr_merged[15:0];
        if (wr && word == W_STATUS && wb.wbs_sel_i[0] && wb.wbs_dat_i[0])
            hit_next = 1'b0;

        // Counter source priority: LA load, then Wishbone COUNT, then step.
        if (la_load) begin
            count_next = la_data_i;
        end else if (wb_count_wr) begin
            count_next = wr_merged[BITS-1:0];
        end else if (step_ok) begin
            if (at_term) begin
                if (wrap_en) count_next = dir ? '0 : limit_reg;
            end else begin
                count_next = dir ? count_reg + ONE : count_reg - ONE;
            end
        end

        // Set after clear so a simultaneous W1C loses to a new hit.
        if (step_ok && at_term) hit_next = 1'b1;
        // Applied last so a concurrent CTRL write cannot re-enable a stopped counter.
        if (auto_clear) ctrl_next[0] = 1'b0;

        if (!en || la_load || wb_count_wr || tick) pre_cnt_next = '0;
        else                                      pre_cnt_next = pre_cnt_reg + 16'd1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_reg    <= ST_IDLE;
            dat_o_reg    <= '0;
            ctrl_reg     <= '0;
            count_reg    <= '0;
            limit_reg    <= '1;
            hit_reg      <= 1'b0;
            prescale_reg <= '0;
            pre_cnt_reg  <= '0;
            irq_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            dat_o_reg    <= dat_o_next;
            ctrl_reg     <= ctrl_next;
            count_reg    <= count_next;
            limit_reg    <= limit_next;
            hit_reg      <= hit_next;
            prescale_reg <= prescale_next;
            pre_cnt_reg  <= pre_cnt_next;
            irq_reg      <= hit_reg & ctrl_reg[2];
        end
    end

    assign wb.wbs_ack_o = (state_reg == ST_ACK);
    assign wb.wbs_dat_o = dat_o_reg;
    assign count_o      = count_reg;
    assign io_oeb_o     = {BITS{~ctrl_reg[4]}};
    assign irq_o        = irq_reg;

endmodule

// File: tb/tb_updown_ctrl.sv
// ---------------------------------------------------------------------------
// tb_updown_ctrl
//
// Directed testbench for updown_ctrl: one task per scenario, each with its
// own inline comparisons against hand-computed values.
// ---------------------------------------------------------------------------
module tb_updown_ctrl;

    localparam logic [31:0] BASE       = 32'h3000_0000;
    localparam logic [31:0] A_CTRL     = BASE + 32'h00;
    localparam logic [31:0] A_COUNT    = BASE + 32'h04;
    localparam logic [31:0] A_LIMIT    = BASE + 32'h08;
    localparam logic [31:0] A_STATUS   = BASE + 32'h0C;
    localparam logic [31:0] A_PRESCALE = BASE + 32'h10;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni;
    logic        la_load_i;
    logic        la_oenb_i;
    logic [31:0] la_data_i;
    logic [31:0] count_o;
    logic [31:0] io_oeb_o;
    logic        irq_o;

    int n_cmp = 0;
    int n_bad = 0;

    updown_ctrl_if wb_if ();

    updown_ctrl #(.BITS(32), .BASE(BASE)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .wb        (wb_if),
        .la_load_i (la_load_i),
        .la_oenb_i (la_oenb_i),
        .la_data_i (la_data_i),
        .count_o   (count_o),
        .io_oeb_o  (io_oeb_o),
        .irq_o     (irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // One bus transfer; waits at most 4 edges for ack.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic acked, output logic [31:0] rdata);
        wb_if.wbs_stb_i = 1'b1;
        wb_if.wbs_cyc_i = 1'b1;
        wb_if.wbs_we_i  = we;
        wb_if.wbs_adr_i = adr;
        wb_if.wbs_dat_i = dat;
        wb_if.wbs_sel_i = sel;
        acked = 1'b0;
        rdata = '0;
        for (int i = 0; i < 4 && !acked; i++) begin
            @(posedge wb_clk_i); #1;
            if (wb_if.wbs_ack_o) begin
                acked = 1'b1;
                rdata = wb_if.wbs_dat_o;
            end
        end
        wb_if.wbs_stb_i = 1'b0;
        wb_if.wbs_cyc_i = 1'b0;
        wb_if.wbs_we_i  = 1'b0;
    endtask

    task automatic wb_wr(input logic [31:0] adr, input logic [31:0] dat);
        logic ok;
        logic [31:0] rd;
        wb_xfer(1'b1, adr, dat, 4'hF, ok, rd);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++;
            $display("FAIL wr_ack adr=%h got ack=%b want 1", adr, ok);
        end
        $display("write %h <= %h ack=%b", adr, dat, ok);
    endtask

    task automatic wb_rd(input logic [31:0] adr, output logic [31:0] rd);
        logic ok;
        wb_xfer(1'b0, adr, 32'd0, 4'hF, ok, rd);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++;
            $display("FAIL rd_ack adr=%h got ack=%b want 1", adr, ok);
        end
        $display("read  %h => %h ack=%b", adr, rd, ok);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [5:0]  pat;
        logic [31:0] idle_or;
        wb_rst_ni = 1'b0;
        repeat (2) @(posedge wb_clk_i);
        #1;
        n_cmp++; if (wb_if.wbs_ack_o !== 1'b0) begin n_bad++; $display("FAIL rst_ack got %b want 0", wb_if.wbs_ack_o); end
        n_cmp++; if (wb_if.wbs_dat_o !== 32'd0) begin n_bad++; $display("FAIL rst_dat got %h want 0", wb_if.wbs_dat_o); end
        n_cmp++; if (count_o !== 32'd0) begin n_bad++; $display("FAIL rst_count got %h want 0", count_o); end
        n_cmp++; if (irq_o !== 1'b0) begin n_bad++; $display("FAIL rst_irq got %b want 0", irq_o); end
        n_cmp++; if (io_oeb_o !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rst_oeb got %h want ffffffff", io_oeb_o); end
        wb_rst_ni = 1'b1;
        wb_rd(A_LIMIT, rd);
        n_cmp++; if (rd !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rst_limit got %h want ffffffff", rd); end

        // Strobe held high: ack must toggle every cycle, data zero when no ack.
        @(posedge wb_clk_i); #1;
        wb_if.wbs_stb_i = 1'b1;
        wb_if.wbs_cyc_i = 1'b1;
        wb_if.wbs_we_i  = 1'b0;
        wb_if.wbs_adr_i = A_LIMIT;
        pat = '0;
        idle_or = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge wb_clk_i); #1;
            pat[5-i] = wb_if.wbs_ack_o;
            if (!wb_if.wbs_ack_o) idle_or = idle_or | wb_if.wbs_dat_o;
        end
        wb_if.wbs_stb_i = 1'b0;
        wb_if.wbs_cyc_i = 1'b0;
        n_cmp++; if (pat !== 6'b101010) begin n_bad++; $display("FAIL b2b_ack got %b want 101010", pat); end
        n_cmp++; if (idle_or !== 32'd0) begin n_bad++; $display("FAIL b2b_idle_dat got %h want 0", idle_or); end
        $display("test_reset done ack pattern=%b", pat);
    endtask

    task automatic test_up_stop();
        logic [31:0] rd;
        logic [31:0] exp_cnt [3];
        logic        exp_irq [3];
        exp_cnt[0] = 32'd4; exp_cnt[1] = 32'd5; exp_cnt[2] = 32'd5;
        exp_irq[0] = 1'b0;  exp_irq[1] = 1'b0;  exp_irq[2] = 1'b0;
        wb_wr(A_LIMIT, 32'd5);
        wb_wr(A_COUNT, 32'd3);
        wb_wr(A_PRESCALE, 32'd0);
        wb_wr(A_CTRL, 32'h07);
        for (int i = 0; i < 3; i++) begin
            @(posedge wb_clk_i); #1;
            n_cmp++; if (count_o !== exp_cnt[i]) begin n_bad++; $display("FAIL up_count[%0d] got %h want %h", i, count_o, exp_cnt[i]); end
            n_cmp++; if (irq_o !== exp_irq[i]) begin n_bad++; $display("FAIL up_irq_early[%0d] got %b want %b", i, irq_o, exp_irq[i]); end
        end
        @(posedge wb_clk_i); #1;
        n_cmp++; if (irq_o !== 1'b1) begin n_bad++; $display("FAIL up_irq got %b want 1", irq_o); end
        wb_rd(A_CTRL, rd);
        n_cmp++; if (rd !== 32'h06) begin n_bad++; $display("FAIL up_ctrl_en got %h want 06", rd); end
        wb_rd(A_STATUS, rd);
        n_cmp++; if (rd !== 32'h01) begin n_bad++; $display("FAIL up_hit got %h want 01", rd); end
        n_cmp++; if (count_o !== 32'd5) begin n_bad++; $display("FAIL up_hold got %h want 5", count_o); end
        wb_wr(A_STATUS, 32'h1);
        @(posedge wb_clk_i); #1;
        n_cmp++; if (irq_o !== 1'b0) begin n_bad++; $display("FAIL up_irq_clr got %b want 0", irq_o); end
        $display("test_up_stop done count=%h", count_o);
    endtask

    task automatic test_down_wrap();
        logic [31:0] rd;
        logic [31:0] exp_cnt [9];
        exp_cnt[0] = 32'd1; exp_cnt[1] = 32'd1; exp_cnt[2] = 32'd0;
        exp_cnt[3] = 32'd0; exp_cnt[4] = 32'd0; exp_cnt[5] = 32'd9;
        exp_cnt[6] = 32'd9; exp_cnt[7] = 32'd9; exp_cnt[8] = 32'd8;
        wb_wr(A_CTRL, 32'h00);
        wb_wr(A_COUNT, 32'd1);
        wb_wr(A_LIMIT, 32'd9);
        wb_wr(A_PRESCALE, 32'd2);
        wb_wr(A_CTRL, 32'h09);
        for (int i = 0; i < 9; i++) begin
            @(posedge wb_clk_i); #1;
            n_cmp++; if (count_o !== exp_cnt[i]) begin n_bad++; $display("FAIL down_count[%0d] got %h want %h", i, count_o, exp_cnt[i]); end
        end
        n_cmp++; if (irq_o !== 1'b0) begin n_bad++; $display("FAIL down_irq_masked got %b want 0", irq_o); end
        wb_wr(A_CTRL, 32'h00);
        wb_rd(A_STATUS, rd);
        n_cmp++; if (rd !== 32'h01) begin n_bad++; $display("FAIL down_hit got %h want 01", rd); end
        n_cmp++; if (count_o !== 32'd8) begin n_bad++; $display("FAIL down_stop got %h want 8", count_o); end
        wb_wr(A_STATUS, 32'h1);
        wb_rd(A_STATUS, rd);
        n_cmp++; if (rd !== 32'h00) begin n_bad++; $display("FAIL down_w1c got %h want 0", rd); end
        $display("test_down_wrap done count=%h", count_o);
    endtask

    task automatic test_arbitration();
        wb_wr(A_LIMIT, 32'h1000);
        wb_wr(A_PRESCALE, 32'd0);
        wb_wr(A_CTRL, 32'h0B);
        // LA load, Wishbone COUNT write and a tick all meet on one edge.
        @(posedge wb_clk_i); #1;
        la_load_i = 1'b1;
        la_oenb_i = 1'b0;
        la_data_i = 32'h55;
        wb_if.wbs_stb_i = 1'b1;
        wb_if.wbs_cyc_i = 1'b1;
        wb_if.wbs_we_i  = 1'b1;
        wb_if.wbs_sel_i = 4'hF;
        wb_if.wbs_adr_i = A_COUNT;
        wb_if.wbs_dat_i = 32'hAA;
        @(posedge wb_clk_i); #1;
        n_cmp++; if (wb_if.wbs_ack_o !== 1'b1) begin n_bad++; $display("FAIL arb_ack got %b want 1", wb_if.wbs_ack_o); end
        n_cmp++; if (count_o !== 32'h55) begin n_bad++; $display("FAIL arb_la_wins got %h want 55", count_o); end
        la_load_i = 1'b0;
        la_oenb_i = 1'b1;
        wb_if.wbs_stb_i = 1'b0;
        wb_if.wbs_cyc_i = 1'b0;
        wb_if.wbs_we_i  = 1'b0;
        wb_wr(A_COUNT, 32'hAA);
        n_cmp++; if (count_o !== 32'hAA) begin n_bad++; $display("FAIL arb_wb_load got %h want aa", count_o); end
        @(posedge wb_clk_i); #1;
        n_cmp++; if (count_o !== 32'hAB) begin n_bad++; $display("FAIL arb_step_resume got %h want ab", count_o); end
        wb_wr(A_CTRL, 32'h00);
        $display("test_arbitration done count=%h", count_o);
    endtask

    task automatic test_decode();
        logic        ok;
        logic [31:0] rd;
        wb_xfer(1'b1, A_PRESCALE, 32'hFFFF_FFFF, 4'b0001, ok, rd);
        wb_rd(A_PRESCALE, rd);
        n_cmp++; if (rd !== 32'h0000_00FF) begin n_bad++; $display("FAIL sel_byte0 got %h want 000000ff", rd); end
        wb_xfer(1'b1, A_PRESCALE, 32'h1234_5600, 4'b0010, ok, rd);
        wb_rd(A_PRESCALE, rd);
        n_cmp++; if (rd !== 32'h0000_56FF) begin n_bad++; $display("FAIL sel_byte1 got %h want 000056ff", rd); end
        wb_xfer(1'b0, BASE + 32'h100, 32'd0, 4'hF, ok, rd);
        n_cmp++; if (ok !== 1'b0) begin n_bad++; $display("FAIL out_window_ack got %b want 0", ok); end
        $display("read  %h ack=%b", BASE + 32'h100, ok);
        wb_rd(BASE + 32'h20, rd);
        n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL unmapped_rd got %h want 0", rd); end
        wb_wr(BASE + 32'h24, 32'hFFFF_FFFF);
        wb_rd(A_CTRL, rd);
        n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL unmapped_wr got %h want 0", rd); end
        $display("test_decode done");
    endtask

    task automatic test_pad();
        wb_wr(A_CTRL, 32'h10);
        n_cmp++; if (io_oeb_o !== 32'd0) begin n_bad++; $display("FAIL oe_on got %h want 0", io_oeb_o); end
        wb_wr(A_COUNT, 32'h33);
        la_data_i = 32'h77;
        la_load_i = 1'b1;
        la_oenb_i = 1'b1;
        repeat (2) @(posedge wb_clk_i);
        #1;
        n_cmp++; if (count_o !== 32'h33) begin n_bad++; $display("FAIL la_gated got %h want 33", count_o); end
        la_oenb_i = 1'b0;
        @(posedge wb_clk_i); #1;
        n_cmp++; if (count_o !== 32'h77) begin n_bad++; $display("FAIL la_load got %h want 77", count_o); end
        la_load_i = 1'b0;
        la_oenb_i = 1'b1;
        wb_wr(A_CTRL, 32'h00);
        n_cmp++; if (io_oeb_o !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL oe_off got %h want ffffffff", io_oeb_o); end
        $display("test_pad done count=%h", count_o);
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        @(posedge wb_clk_i); #1;
        wb_if.wbs_stb_i = 1'b1;
        wb_if.wbs_cyc_i = 1'b1;
        wb_if.wbs_we_i  = 1'b1;
        wb_if.wbs_sel_i = 4'hF;
        wb_if.wbs_adr_i = A_LIMIT;
        wb_if.wbs_dat_i = 32'h22;
        wb_rst_ni = 1'b0;
        @(posedge wb_clk_i); #1;
        n_cmp++; if (wb_if.wbs_ack_o !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ack got %b want 0", wb_if.wbs_ack_o); end
        wb_if.wbs_stb_i = 1'b0;
        wb_if.wbs_cyc_i = 1'b0;
        wb_if.wbs_we_i  = 1'b0;
        wb_rst_ni = 1'b1;
        wb_rd(A_LIMIT, rd);
        n_cmp++; if (rd !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mid_rst_lost got %h want ffffffff", rd); end
        $display("test_reset_mid done");
    endtask

    initial begin
        wb_rst_ni = 1'b0;
        la_load_i = 1'b0;
        la_oenb_i = 1'b1;
        la_data_i = '0;
        wb_if.wbs_stb_i = 1'b0;
        wb_if.wbs_cyc_i = 1'b0;
        wb_if.wbs_we_i  = 1'b0;
        wb_if.wbs_sel_i = 4'h0;
        wb_if.wbs_adr_i = '0;
        wb_if.wbs_dat_i = '0;

        test_reset();
        test_up_stop();
        test_down_wrap();
        test_arbitration();
        test_decode();
        test_pad();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
